pipe_stage_reg: RTL and testbench

Parametrised pipeline-boundary register for the OpenMIPS core, the generalised successor of the per-stage latch blocks (if_id, id_ex, ex_mem, mem_wb). It carries an arbitrary-width payload plus a valid bit, applies the shared stall vector, inserts bubbles, and honours an exception flush. It also holds a multi-cycle loop-back channel, such as the madd/msub partial hilo and cycle count, across stalls, and counts bubble cycles for performance analysis. One instance sits between each pair of stages.

---
 rtl/pipe_stage_reg.sv | 73 +++++++
 tb/tb_pipe_stage_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: payload + valid with stall/bubble/flush handling,
// a loop-back channel held across stalls, and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       LOOP_W     = 66,
    parameter int unsigned       STALL_W    = 6,
    parameter int unsigned       STAGE_IDX  = 3,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               clr_cnt,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [LOOP_W-1:0]  loop_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [LOOP_W-1:0]  loop_o,
    output logic [CNT_W-1:0]   bubble_cnt
);

    generate
        if (STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX must lie in 0..STALL_W-2");
        end
    endgenerate

    logic s;
    logic d;
    logic bubble;
    logic stall_unused;

    assign s      = stall[STAGE_IDX];
    assign d      = stall[STAGE_IDX+1];
    assign bubble = s & ~d;
    // Only two bits of the shared stall vector matter to this instance.
    assign stall_unused = ^stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= BUBBLE_VAL;
            loop_o     <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= BUBBLE_VAL;
            loop_o    <= '0;
        end else begin
            if (!s) begin
                out_valid <= in_valid;
                out_data  <= in_valid ? in_data : BUBBLE_VAL;
                loop_o    <= '0;
            end else if (!d) begin
                out_valid <= 1'b0;
                out_data  <= BUBBLE_VAL;
                loop_o    <= loop_i;
            end else begin
                loop_o    <= loop_i;
            end

            if (clr_cnt) begin
                bubble_cnt <= '0;
            end else if (bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues hand-computed expectations,
// a monitor pops and compares after every clock edge.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [65:0] l;
        logic [1:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [65:0] loop_i = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [65:0] loop_o;
    logic [1:0]  bubble_cnt;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    localparam logic [65:0] L1 = 66'h1_0000_0001_0000_0002;
    localparam logic [65:0] L2 = 66'h2_0000_0003_0000_0004;
    localparam logic [65:0] L3 = 66'h3_DEAD_BEEF_0BAD_F00D;

    pipe_stage_reg #(
        .DATA_W(32), .LOOP_W(66), .STALL_W(6), .STAGE_IDX(3),
        .BUBBLE_VAL(32'h0), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .loop_i(loop_i),
        .out_valid(out_valid), .out_data(out_data), .loop_o(loop_o),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every edge presents a new registered output to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                tests += 4;
                if (out_valid !== e.v) begin
                    fails++;
                    $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, e.v);
                end
                if (out_data !== e.d) begin
                    fails++;
                    $display("FAIL out_data @%0t: got %h want %h", $time, out_data, e.d);
                end
                if (loop_o !== e.l) begin
                    fails++;
                    $display("FAIL loop_o @%0t: got %h want %h", $time, loop_o, e.l);
                end
                if (bubble_cnt !== e.c) begin
                    fails++;
                    $display("FAIL bubble_cnt @%0t: got %0d want %0d", $time, bubble_cnt, e.c);
                end
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic c, input logic [5:0] st,
                        input logic iv, input logic [31:0] id, input logic [65:0] li,
                        input logic ev, input logic [31:0] ed, input logic [65:0] el,
                        input logic [1:0] ec);
        exp_t e;
        @(negedge clk);
        rst = r; flush = f; clr_cnt = c; stall = st;
        in_valid = iv; in_data = id; loop_i = li;
        e.v = ev; e.d = ed; e.l = el; e.c = ec;
        q.push_back(e);
    endtask

    initial begin
        //     rst  fl   clr  stall      iv   in_data       loop_i | v    data          loop  cnt
        step(1'b1,1'b0,1'b0,6'b111111,1'b1,32'hDEADBEEF,L1,   1'b0,32'h0,       '0,   2'd0);
        step(1'b1,1'b1,1'b0,6'b111111,1'b1,32'hDEADBEEF,L1,   1'b0,32'h0,       '0,   2'd0);
        // advance
        step(1'b0,1'b0,1'b0,6'b000000,1'b1,32'h12345678,'0,   1'b1,32'h12345678,'0,   2'd0);
        step(1'b0,1'b0,1'b0,6'b000000,1'b0,32'hFFFFFFFF,'0,   1'b0,32'h0,       '0,   2'd0);
        // bubble with loop-back
        step(1'b0,1'b0,1'b0,6'b001111,1'b1,32'h11111111,L1,   1'b0,32'h0,       L1,   2'd1);
        step(1'b0,1'b0,1'b0,6'b001111,1'b1,32'h22222222,L2,   1'b0,32'h0,       L2,   2'd2);
        step(1'b0,1'b0,1'b0,6'b000000,1'b0,32'h0,       L3,   1'b0,32'h0,       '0,   2'd2);
        // hold
        step(1'b0,1'b0,1'b0,6'b000000,1'b1,32'hA5A5A5A5,L3,   1'b1,32'hA5A5A5A5,'0,   2'd2);
        step(1'b0,1'b0,1'b0,6'b011111,1'b1,32'h00000001,L1,   1'b1,32'hA5A5A5A5,L1,   2'd2);
        step(1'b0,1'b0,1'b0,6'b011111,1'b0,32'h00000002,L2,   1'b1,32'hA5A5A5A5,L2,   2'd2);
        step(1'b0,1'b0,1'b0,6'b011111,1'b1,32'h00000003,L3,   1'b1,32'hA5A5A5A5,L3,   2'd2);
        // flush beats bubble, counter untouched
        step(1'b0,1'b1,1'b0,6'b001111,1'b1,32'h00000077,L2,   1'b0,32'h0,       '0,   2'd2);
        // only S and D matter: downstream-only stall and unrelated bits still advance
        step(1'b0,1'b0,1'b0,6'b010000,1'b1,32'hCAFEF00D,L1,   1'b1,32'hCAFEF00D,'0,   2'd2);
        step(1'b0,1'b0,1'b0,6'b100111,1'b0,32'h55555555,L1,   1'b0,32'h0,       '0,   2'd2);
        // clear, then saturation
        step(1'b0,1'b0,1'b1,6'b000000,1'b0,32'h0,       '0,   1'b0,32'h0,       '0,   2'd0);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       66'h1,1'b0,32'h0,       66'h1,2'd1);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       66'h2,1'b0,32'h0,       66'h2,2'd2);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       66'h3,1'b0,32'h0,       66'h3,2'd3);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       66'h4,1'b0,32'h0,       66'h4,2'd3);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       66'h5,1'b0,32'h0,       66'h5,2'd3);
        // clear wins over same-cycle increment
        step(1'b0,1'b0,1'b1,6'b001111,1'b0,32'h0,       L1,   1'b0,32'h0,       L1,   2'd0);
        step(1'b0,1'b0,1'b0,6'b001111,1'b0,32'h0,       L2,   1'b0,32'h0,       L2,   2'd1);
        // flush blocks clr_cnt
        step(1'b0,1'b1,1'b1,6'b001111,1'b1,32'h99999999,L3,   1'b0,32'h0,       '0,   2'd1);
        step(1'b0,1'b0,1'b0,6'b011111,1'b1,32'h88888888,L3,   1'b0,32'h0,       L3,   2'd1);
        // reset mid-stall clears everything
        step(1'b1,1'b0,1'b0,6'b001111,1'b1,32'h44444444,L2,   1'b0,32'h0,       '0,   2'd0);
        step(1'b0,1'b0,1'b0,6'b000000,1'b1,32'h01020304,'0,   1'b1,32'h01020304,'0,   2'd0);

        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
